maxima_serializer_arbiter: RTL and testbench
============================================

Name: maxima_serializer_arbiter

Overview:
Shares one maxima PISO serializer between NUM_REQ peak-extraction units. Each unit presents a vector of MAXIMAS_COUNT spectral-peak bin indices. The arbiter grants units in round-robin order, loads the granted vector into the PISO and tracks the burst through the PISO's output_active flag. It then acknowledges the unit and tags the serial stream with the source id for the downstream hash/fingerprint stage.

Parameters:
NUM_REQ, 4, number of requesting peak-extraction units (2..8)
MAXIMAS_COUNT, 11, peaks per vector; must match the PISO instance
BIN_W, 9, width of one peak bin index
TIMEOUT, 32, max cycles spent waiting for the PISO burst to start or finish

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-unit request; held high with stable data until ack
req_data  in  NUM_REQ*MAXIMAS_COUNT*BIN_W  flattened vectors; unit u, peak i at bits [(u*MAXIMAS_COUNT+i)*BIN_W +: BIN_W]
ack  out  NUM_REQ  one-cycle completion pulse to the granted unit
piso_load  out  1  one-cycle load strobe to the PISO
piso_data  out  MAXIMAS_COUNT*BIN_W  granted vector, peak i at [i*BIN_W +: BIN_W]
piso_active  in  1  PISO output_active
src_id  out  max(1,$clog2(NUM_REQ))  index of the unit currently owning the PISO
src_valid  out  1  high while src_id tags the PISO stream
busy  out  1  high in every state except IDLE
err_timeout  out  1  sticky PISO-timeout flag

Behaviour:
- Reset (async, active-high) values: state=IDLE, ack=0, piso_load=0, src_id=0, src_valid=0, busy=0, err_timeout=0, rr_ptr=NUM_REQ-1 (so unit 0 has first priority), timeout counter=0. Reset mid-burst aborts at once with no ack. The PISO shares the same reset.
- States are IDLE, LOAD, WAIT_START, STREAM and DONE. All outputs are registered or decoded from registered state only.
- IDLE: if any req bit is high, the grant goes to the first set bit searching from rr_ptr+1 with wrap. The grant is registered into src_id, and the next state is LOAD.
- LOAD: piso_load=1 for exactly this cycle. piso_data=req_data[src_id] (the mux is driven by registered src_id and is valid from LOAD through DONE; 0 in IDLE). Next state is WAIT_START and the counter is cleared.
- WAIT_START: wait for piso_active=1, which goes to STREAM with the counter cleared. The nominal wait is 2 cycles after the LOAD cycle.
- STREAM: wait for piso_active=0, which goes to DONE. The nominal stay is MAXIMAS_COUNT cycles.
- DONE: ack[src_id]=1 for one cycle, rr_ptr<=src_id, next state IDLE.
- src_valid=1 in WAIT_START and STREAM.
- Timeout: the counter increments each cycle in WAIT_START and STREAM. On reaching TIMEOUT, err_timeout<=1 (held until reset) and the state goes to DONE. The unit is still acked so it does not hang.
- Requester rules: the unit drops req at the clock edge after it sees ack. Because IDLE samples req one cycle after DONE, the next grant back-to-back is never a stale re-grant. A req deasserted before grant is simply not selected. A req deasserted while granted is ignored; the burst completes on the latched id.
- Simultaneous events: new requests arriving while busy wait. Multiple requests are resolved strictly by round-robin. A fresh req on the unit just acked is the lowest priority in the next arbitration.
- Throughput: one vector per MAXIMAS_COUNT+5 cycles nominal (IDLE, LOAD, 2-cycle start, MAXIMAS_COUNT stream, DONE).
- Widths: the counter is $clog2(TIMEOUT+1) bits. The rr pointer is the src_id width. Index arithmetic wraps modulo NUM_REQ.

Decomposition:
- Package maxima_pkg holds:
  - the arb_state_t enum (IDLE, LOAD, WAIT_START, STREAM, DONE);
  - the defaults MAXIMAS_COUNT=11 and BIN_W=9, shared with the PISO;
  - a helper function computing the src_id width.
- Sub-module rr_arbiter (combinational: req vector + pointer -> grant index + grant_valid), reusable elsewhere. The FSM, mux and counter stay in the top module.

Test Plan:
- Single request: req=4'b0010 with vector 1..11 -> piso_load pulses 1 cycle after grant, piso_data carries 1..11, src_id=1, ack[1] pulses once after piso_active falls, busy=0 afterwards.
- All four req high from reset -> grant order is 0,1,2,3,0 with each ack pulse preceding the next piso_load. The ack spacing is MAXIMAS_COUNT+5=16 cycles.
- req[3] and req[0] raised together after unit 3 was last served -> unit 0 is granted first, then unit 3.
- Tie piso_active low -> after TIMEOUT=32 cycles in WAIT_START, err_timeout=1 stays high and ack pulses. The next request is then still served.
- Assert reset in the middle of STREAM -> all outputs go to 0 immediately, no ack is issued, and the pending req is re-served after reset release starting from unit 0 priority.
- req dropped in LOAD -> the burst completes on the latched id, the ack is issued, and there is no second grant.

Source files
------------

// File: rtl/maxima_pkg.sv
// -----------------------------------------------------------------------------
// maxima_pkg
// Shared definitions for the maxima serializer arbiter and the maxima PISO:
//   - arb_state_t : arbiter FSM state encoding
//   - DEF_MAXIMAS_COUNT / DEF_BIN_W : default vector geometry, which must match
//     the PISO instance
//   - id_width()  : width of a source id for a given number of requesters
// -----------------------------------------------------------------------------
package maxima_pkg;

  localparam int DEF_MAXIMAS_COUNT = 11;
  localparam int DEF_BIN_W         = 9;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_START = 3'd2,
    STREAM     = 3'd3,
    DONE       = 3'd4
  } arb_state_t;

  // A single requester still needs a 1-bit id so the port never collapses.
  function automatic int id_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/maxima_serializer_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at the unit after ptr
// and wraps modulo NUM_REQ, so the unit at ptr (normally the one served last)
// has the lowest priority.
// Ports:
//   req         in  NUM_REQ  request vector
//   ptr         in  IDW      last served index
//   grant       out IDW      selected index (0 when nothing is requested)
//   grant_valid out 1        at least one request bit was set
// -----------------------------------------------------------------------------
module rr_arbiter
  import maxima_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     grant,
  output logic               grant_valid
);

  logic [IDW-1:0] idx_s;

  // First set request walking from ptr+1 with wrap-around.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx_s       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!grant_valid && req[idx_s]) begin
        grant       = idx_s;
        grant_valid = 1'b1;
      end else begin
        grant       = grant;
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/maxima_serializer_arbiter.sv
// -----------------------------------------------------------------------------
// maxima_serializer_arbiter
// Shares one maxima PISO between NUM_REQ peak-extraction units. Units are
// granted in round-robin order; the granted vector is loaded into the PISO,
// the burst is tracked through the PISO output_active flag, and the unit is
// acknowledged once the burst ends (or a timeout fires). The serial stream is
// tagged with the owning unit id.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (shared with the PISO)
//   req          per-unit request, held with stable data until ack
//   req_data     flattened vectors, unit u peak i at [(u*MC+i)*BIN_W +: BIN_W]
//   ack          one-cycle completion pulse to the granted unit
//   piso_load    one-cycle PISO load strobe
//   piso_data    granted vector (0 while idle)
//   piso_active  PISO output_active
//   src_id       id of the unit owning the PISO
//   src_valid    src_id tags the stream (WAIT_START and STREAM)
//   busy         arbiter not idle
//   err_timeout  sticky PISO timeout flag
// -----------------------------------------------------------------------------
module maxima_serializer_arbiter
  import maxima_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAXIMAS_COUNT = DEF_MAXIMAS_COUNT,
  parameter int BIN_W         = DEF_BIN_W,
  parameter int TIMEOUT       = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*MAXIMAS_COUNT*BIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]                ack,
  output logic                              piso_load,
  output logic [MAXIMAS_COUNT*BIN_W-1:0]    piso_data,
  input  logic                              piso_active,
  output logic [id_width(NUM_REQ)-1:0]      src_id,
  output logic                              src_valid,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int VW  = MAXIMAS_COUNT * BIN_W;
  localparam logic [NUM_REQ-1:0] ACK_LSB = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  arb_state_t      state_r, state_nxt;
  logic [CW-1:0]   cnt_r, cnt_nxt;
  logic [IDW-1:0]  rr_ptr_r, rr_ptr_nxt;
  logic [IDW-1:0]  src_id_r, src_id_nxt;
  logic            err_r, err_nxt;
  logic [NUM_REQ-1:0] ack_r;
  logic            piso_load_r;
  logic            src_valid_r;
  logic            busy_r;
  logic [IDW-1:0]  grant_s;
  logic            grant_valid_s;
  logic [VW-1:0]   vec_s [NUM_REQ];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr (
    .req         (req),
    .ptr         (rr_ptr_r),
    .grant       (grant_s),
    .grant_valid (grant_valid_s)
  );

  genvar gu;
  generate
    for (gu = 0; gu < NUM_REQ; gu++) begin : g_vec
      assign vec_s[gu] = req_data[gu*VW +: VW];
    end
  endgenerate

  // FSM state, timeout counter, round-robin pointer, latched id, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      rr_ptr_r <= IDW'(NUM_REQ - 1);
      src_id_r <= '0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      rr_ptr_r <= rr_ptr_nxt;
      src_id_r <= src_id_nxt;
      err_r    <= err_nxt;
    end
  end

  // Next-state logic; the counter only runs while waiting on the PISO.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    rr_ptr_nxt = rr_ptr_r;
    src_id_nxt = src_id_r;
    err_nxt    = err_r;
    case (state_r)
      IDLE: begin
        cnt_nxt = '0;
        if (grant_valid_s) begin
          src_id_nxt = grant_s;
          state_nxt  = LOAD;
        end else begin
          state_nxt  = IDLE;
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (piso_active) begin
          cnt_nxt   = '0;
          state_nxt = STREAM;
        end else if (cnt_r == CNT_LAST) begin
          cnt_nxt   = cnt_r + CNT_ONE;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt_r + CNT_ONE;
        end
      end
      STREAM: begin
        if (!piso_active) begin
          state_nxt = DONE;
        end else if (cnt_r == CNT_LAST) begin
          cnt_nxt   = cnt_r + CNT_ONE;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        // The unit just served becomes the lowest priority next time.
        rr_ptr_nxt = src_id_r;
        cnt_nxt    = '0;
        state_nxt  = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r       <= '0;
      piso_load_r <= 1'b0;
      src_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      ack_r       <= (state_nxt == DONE) ? (ACK_LSB << src_id_r) : '0;
      piso_load_r <= (state_nxt == LOAD);
      src_valid_r <= (state_nxt == WAIT_START) || (state_nxt == STREAM);
      busy_r      <= (state_nxt != IDLE);
    end
  end

  // Vector mux driven by the latched id; zero while idle.
  always_comb begin
    piso_data = '0;
    if (state_r != IDLE) begin
      piso_data = vec_s[src_id_r];
    end else begin
      piso_data = '0;
    end
  end

  assign ack         = ack_r;
  assign piso_load   = piso_load_r;
  assign src_id      = src_id_r;
  assign src_valid   = src_valid_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;

endmodule

// File: tb/tb_maxima_serializer_arbiter.sv
module tb_maxima_serializer_arbiter;

  localparam int N  = 4;
  localparam int MC = 11;
  localparam int BW = 9;
  localparam int TO = 32;
  localparam int VW = MC * BW;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*VW-1:0]   req_data;
  logic [N-1:0]      ack;
  logic              piso_load;
  logic [VW-1:0]     piso_data;
  logic              piso_active;
  logic [1:0]        src_id;
  logic              src_valid;
  logic              busy;
  logic              err_timeout;

  always #5 clk = ~clk;

  maxima_serializer_arbiter #(
    .NUM_REQ(N), .MAXIMAS_COUNT(MC), .BIN_W(BW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .piso_load(piso_load), .piso_data(piso_data), .piso_active(piso_active),
    .src_id(src_id), .src_valid(src_valid), .busy(busy), .err_timeout(err_timeout)
  );

  int errors = 0;
  int checks = 0;

  // reference model: one burst at a time, timing from the nominal schedule
  int  cyc = 0;
  bit  burst_on, prev_busy, burst_dead, err_m;
  int  b_id, b_load, b_ack, last_srv;
  // PISO model
  bit  dead, p_wait;
  int  p_left;
  // requester model
  logic [N-1:0] ack_seen, rearm, pend;
  bit  load_seen;
  logic [VW-1:0] last_load_data;
  int  grants[$];
  int  ack_cycles[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [VW-1:0] vec_of(input int u);
    logic [VW-1:0] v;
    for (int i = 0; i < VW; i++) v[i] = req_data[u*VW + i];
    return v;
  endfunction

  task automatic tick();
    logic [N-1:0] req_c;
    logic [N-1:0] exp_ack;
    bit rst_c;
    bit ack_now;
    req_c = req;
    rst_c = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      piso_active = 1'b0; p_wait = 1'b0; p_left = 0;
    end else begin
      if (piso_active) begin
        p_left--;
        if (p_left == 0) piso_active = 1'b0;
      end else if (p_wait) begin
        piso_active = 1'b1; p_left = MC; p_wait = 1'b0;
      end
      if (load_seen && !dead) p_wait = 1'b1;
    end
    req  = req | pend;
    pend = ack_seen & rearm;
    req  = req & ~ack_seen;
    @(negedge clk);
    if (!rst_c && !prev_busy && req_c != '0) begin
      burst_on   = 1'b1;
      b_id       = rr_pick(req_c, last_srv);
      b_load     = cyc;
      burst_dead = dead;
      b_ack      = dead ? cyc + TO + 1 : cyc + MC + 3;
    end
    ack_now = burst_on && (cyc == b_ack);
    check("piso_load", piso_load, burst_on && cyc == b_load);
    if (burst_on && cyc == b_load) begin
      check("src_id", src_id, b_id);
      check("piso_data", piso_data, vec_of(b_id));
    end
    check("busy", busy, burst_on);
    check("src_valid", src_valid, burst_on && cyc > b_load && cyc < b_ack);
    exp_ack = '0;
    if (ack_now) exp_ack[b_id] = 1'b1;
    check("ack", ack, exp_ack);
    if (ack_now) err_m = err_m | burst_dead;
    check("err_timeout", err_timeout, err_m);
    prev_busy = burst_on;
    if (ack_now) begin
      burst_on = 1'b0;
      last_srv = b_id;
    end
    if (piso_load) begin
      grants.push_back(int'(src_id));
      last_load_data = piso_data;
    end
    if (ack != '0) ack_cycles.push_back(cyc);
    load_seen = piso_load;
    ack_seen  = ack;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_ack", ack, '0);
    check("rst_load", piso_load, 1'b0);
    check("rst_src_id", src_id, '0);
    check("rst_src_valid", src_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_piso_data", piso_data, '0);
    burst_on = 1'b0; prev_busy = 1'b0; err_m = 1'b0; last_srv = N - 1;
    piso_active = 1'b0; p_wait = 1'b0; p_left = 0;
    pend = '0; ack_seen = '0; load_seen = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((req != '0 || burst_on) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", (req == '0) && !burst_on, 1'b1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, abase, n;
    int exp_order[5];
    logic [VW-1:0] exp_vec;
    reset = 1'b1; req = '0; req_data = '0; piso_active = 1'b0;
    dead = 1'b0; rearm = '0; pend = '0; ack_seen = '0; load_seen = 1'b0;
    do_reset();

    // single request on unit 1, vector 1..11
    for (int i = 0; i < MC; i++) begin
      req_data[(1*MC + i)*BW +: BW] = BW'(i + 1);
      exp_vec[i*BW +: BW] = BW'(i + 1);
    end
    base = grants.size(); abase = ack_cycles.size();
    req = 4'b0010;
    drain(60);
    check("single_grants", grants.size() - base, 1);
    if (grants.size() > base) check("single_id", grants[base], 1);
    check("single_vector", last_load_data, exp_vec);
    check("single_acks", ack_cycles.size() - abase, 1);
    check("single_busy_after", busy, 1'b0);

    // all four held from reset: 0,1,2,3,0, acks 16 cycles apart
    do_reset();
    for (int i = 0; i < N*MC; i++) req_data[i*BW +: BW] = BW'($urandom);
    base = grants.size(); abase = ack_cycles.size();
    rearm = 4'b1111; req = 4'b1111;
    n = 0;
    while (ack_cycles.size() - abase < 5 && n < 200) begin
      tick();
      n++;
    end
    req = '0; rearm = '0; pend = '0;
    drain(60);
    exp_order = '{0, 1, 2, 3, 0};
    check("rr_count", grants.size() - base, 5);
    for (int i = 0; i < 5; i++)
      if (grants.size() > base + i) check("rr_order", grants[base + i], exp_order[i]);
    for (int i = 0; i < 4; i++)
      if (ack_cycles.size() > abase + i + 1)
        check("ack_spacing", ack_cycles[abase+i+1] - ack_cycles[abase+i], MC + 5);

    // unit 3 served, then 3 and 0 together -> 0 first
    req = 4'b1000;
    drain(60);
    base = grants.size();
    req = 4'b1001;
    drain(100);
    check("pair_count", grants.size() - base, 2);
    if (grants.size() > base + 1) begin
      check("pair_first", grants[base], 0);
      check("pair_second", grants[base + 1], 3);
    end

    // dead PISO -> timeout, sticky error, ack; next request still served
    dead = 1'b1;
    abase = ack_cycles.size();
    req = 4'b0100;
    drain(100);
    check("timeout_ack", ack_cycles.size() - abase, 1);
    check("timeout_err", err_timeout, 1'b1);
    dead = 1'b0;
    base = grants.size();
    req = 4'b0001;
    drain(60);
    if (grants.size() > base) check("after_timeout_id", grants[base], 0);
    check("timeout_err_sticky", err_timeout, 1'b1);

    // reset in the middle of STREAM
    do_reset();
    req = 4'b0001;
    drain(60);
    req = 4'b0101;
    n = 0;
    while (!(src_valid && piso_active) && n < 20) begin
      tick();
      n++;
    end
    check("reached_stream", src_valid && piso_active, 1'b1);
    tick(); tick(); tick();
    base = grants.size(); abase = ack_cycles.size();
    do_reset();
    check("no_ack_in_reset", ack_cycles.size() - abase, 0);
    drain(100);
    check("rst_regrant_count", grants.size() - base, 2);
    if (grants.size() > base + 1) begin
      check("rst_regrant_first", grants[base], 0);
      check("rst_regrant_second", grants[base + 1], 2);
    end

    // req dropped in LOAD: burst completes, single grant and ack
    base = grants.size(); abase = ack_cycles.size();
    req = 4'b0010;
    n = 0;
    while (!piso_load && n < 5) begin
      tick();
      n++;
    end
    check("drop_load_seen", piso_load, 1'b1);
    req = '0;
    drain(60);
    check("drop_grants", grants.size() - base, 1);
    check("drop_acks", ack_cycles.size() - abase, 1);

    // randomized masks, late arrivals while busy
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N*MC; i++) req_data[i*BW +: BW] = BW'($urandom);
      req = N'($urandom_range(1, 15));
      n = $urandom_range(0, 20);
      for (int k = 0; k < n; k++) tick();
      req = req | N'($urandom_range(0, 15));
      drain(300);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
